fib_recursive_top: RTL and testbench

//   Computes the Fibonacci number F(N) for a 3-bit N. F(0)=F(1)=1, F(n)=F(n-1)+F(n-2).

---
 rtl/fib_recursive_top.sv | 80 ++++++++
 tb/tb_fib_recursive_top.sv | 115 +++++++++++
 2 files changed

// File: rtl/fib_recursive_top.sv
// Recursive Fibonacci engine: an FSM walks the call tree with a LIFO frame stack
// and counts leaves. A run starts automatically when reset is released.
module fib_recursive_top #(
  parameter int NW    = 3,
  parameter int OW    = 5,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NW-1:0] N,
  output logic [OW-1:0] out,
  output logic          done
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {LOAD, FETCH, EXPAND, FIN} state_t;

  state_t        r_state;
  logic [AW-1:0] r_sp;
  logic [OW-1:0] r_acc;
  logic [OW-1:0] r_out;
  logic          r_done;
  logic [NW-1:0] r_n;
  logic [NW-1:0] r_stack [DEPTH];

  logic [AW-1:0] w_top;
  logic [AW-1:0] w_sp1;
  logic          w_leaf;

  assign w_top  = r_sp - AW'(1);
  assign w_sp1  = r_sp + AW'(1);
  assign w_leaf = (r_n < NW'(2));
  assign out    = r_out;
  assign done   = r_done;

  // Stack contents are deliberately left out of reset; every frame is written before it is read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOAD;
      r_sp    <= '0;
      r_acc   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_n     <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          r_stack[0] <= N;
          r_sp       <= AW'(1);
          r_acc      <= '0;
          r_state    <= FETCH;
        end
        FETCH: begin
          if (r_sp == '0) begin
            r_out   <= r_acc;
            r_done  <= 1'b1;
            r_state <= FIN;
          end else begin
            r_n     <= r_stack[w_top];
            r_sp    <= w_top;
            r_state <= EXPAND;
          end
        end
        EXPAND: begin
          // n-2 goes on top so it is popped before its n-1 sibling
          if (w_leaf) begin
            r_acc <= r_acc + OW'(1);
          end else begin
            r_stack[r_sp]  <= r_n - NW'(1);
            r_stack[w_sp1] <= r_n - NW'(2);
            r_sp           <= r_sp + AW'(2);
          end
          r_state <= FETCH;
        end
        FIN: r_state <= FIN;
        default: r_state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_fib_recursive_top.sv
// Directed + randomized bench for fib_recursive_top against an arithmetic
// model of F(N) and call-tree node count.
module tb_fib_recursive_top;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] N   = '0;
  logic [4:0] out;
  logic       done;

  int cmp = 0;
  int bad = 0;
  int fibm [8];
  int tm   [8];

  fib_recursive_top dut (.clk(clk), .rst(rst), .N(N), .out(out), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Assert reset (async), check cleared outputs, release it away from a clock edge.
  task automatic start(input int n, input int hold);
    N   = 3'(n);
    rst = 1'b0;
    #1;
    chk("rst_out", 32'(out), 0);
    chk("rst_done", 32'(done), 0);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk("rst_hold_out", 32'(out), 0);
      chk("rst_hold_done", 32'(done), 0);
    end else begin
      #9;
    end
    rst = 1'b1;
  endtask

  // Count edges after release until done; optionally change N at edge chg_at.
  task automatic finish_run(input int n, input int chg_at, input int chg_val, input string tag);
    int lat;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == chg_at) N = 3'(chg_val);
      if (done === 1'b1) break;
      chk({tag, "_busy_out"}, 32'(out), 0);
    end
    chk({tag, "_timeout"}, 32'(lat < 200), 1);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_out"}, 32'(out), 32'(fibm[n]));
    chk({tag, "_lat"}, 32'(lat), 32'(2 * tm[n] + 2));
  endtask

  initial begin
    int rn, rc, rv;
    fibm[0] = 1; fibm[1] = 1; tm[0] = 1; tm[1] = 1;
    for (int i = 2; i < 8; i++) begin
      fibm[i] = fibm[i-1] + fibm[i-2];
      tm[i]   = 1 + tm[i-1] + tm[i-2];
    end

    // Reset values with clock running, then full sweep
    start(0, 3);
    finish_run(0, 0, 0, "n0");
    for (int n = 1; n < 8; n++) begin
      start(n, 2);
      finish_run(n, 0, 0, $sformatf("n%0d", n));
    end

    // Hold after done, then reset must clear out asynchronously
    start(5, 0);
    finish_run(5, 0, 0, "hold5");
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      chk("hold_out", 32'(out), 8);
      chk("hold_done", 32'(done), 1);
    end
    start(4, 0);
    finish_run(4, 0, 0, "after_hold4");

    // Operand isolation
    start(6, 0);
    finish_run(6, 5, 2, "iso6");

    // Abort mid-run
    start(7, 0);
    repeat (30) @(posedge clk);
    #1;
    chk("mid_done", 32'(done), 0);
    start(4, 0);
    finish_run(4, 0, 0, "abort4");

    // Back-to-back short reset pulses with random operands and mid-run N changes
    for (int k = 0; k < 10; k++) begin
      rn = int'($urandom_range(0, 7));
      rc = int'($urandom_range(2, 40));
      rv = int'($urandom_range(0, 7));
      start(rn, 0);
      finish_run(rn, rc, rv, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
